// File: rtl/instr_encoder.sv
// instr_encoder: assembles RISC-V words from field requests and loads them sequentially into imem
module instr_encoder #(
   parameter int DEPTH = 64,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [2:0]    req_cls,
   input  logic [2:0]    req_funct3,
   input  logic          req_funct7b5,
   input  logic [4:0]    req_rd,
   input  logic [4:0]    req_rs1,
   input  logic [4:0]    req_rs2,
   input  logic [31:0]   req_imm,
   input  logic          seal,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic [AW:0]   count,
   output logic          err,
   output logic          done
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [31:0] NOP = 32'h00000013;
   typedef enum logic [1:0] {LOAD, PAD, DONE} state_t;
   state_t state, state_n;
   logic signed [31:0] simm;
   logic i_ok, b_ok, j_ok, u_ok, sh_ok, shift, imm_ok, accept, wrote, step;
   logic [31:0] enc;
   logic [AW:0] count_n;
   assign simm = $signed(req_imm);
   assign accept = req_valid && req_ready;
   assign wrote = accept && imm_ok;
   assign step = state == PAD || wrote;
   assign count_n = count + {{AW{1'b0}}, step};
   // immediate range checks and field packing per instruction class
   always_comb begin
      i_ok = simm >= -2048 && simm <= 2047;
      b_ok = simm >= -4096 && simm <= 4094 && !req_imm[0];
      j_ok = simm >= -1048576 && simm <= 1048574 && !req_imm[0];
      u_ok = req_imm[11:0] == 12'd0;
      sh_ok = req_imm < 32'd32;
      shift = req_cls == 3'd5 && req_funct3[1:0] == 2'b01;
      imm_ok = 1'b0;
      enc = '0;
      case (req_cls)
         3'd0: begin
            imm_ok = i_ok;
            enc = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
         end
         3'd1: begin
            imm_ok = i_ok;
            enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1000011};
         end
         3'd2: begin
            imm_ok = i_ok;
            enc = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
         end
         3'd3: begin
            imm_ok = 1'b1;
            enc = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
         end
         3'd4: begin
            imm_ok = b_ok;
            enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3, req_imm[4:1], req_imm[11], 7'b1100011};
         end
         3'd5: begin
            imm_ok = shift ? sh_ok : i_ok;
            enc = shift ? {1'b0, req_funct7b5, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, 7'b0010011}
                        : {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
         end
         3'd6: begin
            imm_ok = j_ok;
            enc = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
         end
         default: begin
            imm_ok = u_ok;
            enc = {req_imm[31:12], req_rd, 7'b0110111};
         end
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else state <= state_n;
   end
   // next state: filling memory always wins, a seal with room left starts padding
   always_comb begin
      state_n = state == LOAD ? (count_n == FULL ? DONE : seal ? PAD : LOAD)
              : state == PAD ? (count_n == FULL ? DONE : PAD) : DONE;
   end
   // handshake and completion outputs
   always_comb begin
      req_ready = !reset && state == LOAD && count < FULL;
      done = state == DONE;
   end
   // registered write port, word counter and sticky reject flag
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         err <= 1'b0;
      end else begin
         count <= count_n;
         wr_en <= step;
         if (step) begin
            wr_addr <= count[AW-1:0];
            wr_data <= state == PAD ? NOP : enc;
         end
         if (accept && !imm_ok) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed scoreboard bench for instr_encoder at DEPTH 64 and 4
module tb_instr_encoder;
   typedef struct packed {logic [31:0] a; logic [31:0] d;} exp_t;
   logic clk = 0;
   logic rst_a, rst_b, va, vb, seal_a, seal_b, f7;
   logic [2:0] cls, f3;
   logic [4:0] rd, rs1, rs2;
   logic [31:0] imm;
   logic ready_a, wen_a, err_a, done_a, ready_b, wen_b, err_b, done_b;
   logic [5:0] waddr_a;
   logic [1:0] waddr_b;
   logic [31:0] wdata_a, wdata_b;
   logic [6:0] count_a;
   logic [2:0] count_b;
   exp_t qa[$], qb[$];
   exp_t ea, eb;
   int n_chk = 0, n_fail = 0;
   int cnt_a, cnt_b;
   bit err_am, err_bm, sealed_b;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(64)) dut_a (
      .clk(clk), .reset(rst_a), .req_valid(va), .req_ready(ready_a), .req_cls(cls),
      .req_funct3(f3), .req_funct7b5(f7), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2),
      .req_imm(imm), .seal(seal_a), .wr_en(wen_a), .wr_addr(waddr_a), .wr_data(wdata_a),
      .count(count_a), .err(err_a), .done(done_a));

   instr_encoder #(.DEPTH(4)) dut_b (
      .clk(clk), .reset(rst_b), .req_valid(vb), .req_ready(ready_b), .req_cls(cls),
      .req_funct3(f3), .req_funct7b5(f7), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2),
      .req_imm(imm), .seal(seal_b), .wr_en(wen_b), .wr_addr(waddr_b), .wr_data(wdata_b),
      .count(count_b), .err(err_b), .done(done_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ISA-level reference: range rules and bit placement straight from the instruction formats
   function automatic void enc_ref(input logic [2:0] c, input logic [2:0] fn3, input logic fb5,
                                   input logic [4:0] d5, input logic [4:0] s15, input logic [4:0] s25,
                                   input logic [31:0] u, output bit ok, output logic [31:0] w);
      int v;
      logic [31:0] d, s1, s2, fn, fb;
      v = int'($signed(u));
      d = 32'(d5); s1 = 32'(s15); s2 = 32'(s25); fn = 32'(fn3); fb = 32'(fb5);
      ok = v >= -2048 && v <= 2047;
      w = 0;
      case (c)
         3'd0: w = 32'h03 | d << 7 | 32'd2 << 12 | s1 << 15 | (u & 32'hFFF) << 20;
         3'd1: w = 32'h43 | d << 7 | s1 << 15 | (u & 32'hFFF) << 20;
         3'd2: w = 32'h23 | (u & 31) << 7 | 32'd2 << 12 | s1 << 15 | s2 << 20 | ((u >> 5) & 127) << 25;
         3'd3: begin ok = 1; w = 32'h33 | d << 7 | fn << 12 | s1 << 15 | s2 << 20 | fb << 30; end
         3'd4: begin
            ok = v >= -4096 && v <= 4094 && v % 2 == 0;
            w = 32'h63 | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | fn << 12 | s1 << 15 | s2 << 20
                | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
         end
         3'd5: begin
            if (fn3 == 3'd1 || fn3 == 3'd5) begin
               ok = v >= 0 && v <= 31;
               w = 32'h13 | d << 7 | fn << 12 | s1 << 15 | (u & 31) << 20 | fb << 30;
            end else w = 32'h13 | d << 7 | fn << 12 | s1 << 15 | (u & 32'hFFF) << 20;
         end
         3'd6: begin
            ok = v >= -1048576 && v <= 1048574 && v % 2 == 0;
            w = 32'h6F | d << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20
                | ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
         end
         default: begin ok = (u & 32'hFFF) == 0; w = 32'h37 | d << 7 | (u & 32'hFFFFF000); end
      endcase
   endfunction

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 5))
         0: return 32'($urandom_range(0, 4095)) - 32'd2048;
         1: return 32'($urandom_range(0, 40));
         2: return $urandom;
         3: return 32'($urandom_range(0, 8191)) - 32'd4096;
         4: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
         default: return ($urandom & 32'hFFFFF000) | ($urandom_range(0, 3) == 0 ? 32'h800 : 32'h0);
      endcase
   endfunction

   always @(negedge clk) if (wen_a === 1'b1) begin
      if (qa.size() == 0) chk("spurious wr_en_a", 32'(wen_a), 0);
      else begin
         ea = qa.pop_front();
         chk("wr_addr_a", 32'(waddr_a), ea.a);
         chk("wr_data_a", wdata_a, ea.d);
      end
   end

   always @(negedge clk) if (wen_b === 1'b1) begin
      if (qb.size() == 0) chk("spurious wr_en_b", 32'(wen_b), 0);
      else begin
         eb = qb.pop_front();
         chk("wr_addr_b", 32'(waddr_b), eb.a);
         chk("wr_data_b", wdata_b, eb.d);
      end
   end

   task automatic do_reset();
      rst_a = 1; rst_b = 1; va = 0; vb = 0; seal_a = 0; seal_b = 0;
      @(negedge clk); @(negedge clk);
      chk("ready_a in reset", 32'(ready_a), 0);
      chk("wr_en_a reset", 32'(wen_a), 0);
      chk("wr_addr_a reset", 32'(waddr_a), 0);
      chk("wr_data_a reset", wdata_a, 0);
      chk("count_a reset", 32'(count_a), 0);
      chk("err_a reset", 32'(err_a), 0);
      chk("done_a reset", 32'(done_a), 0);
      chk("count_b reset", 32'(count_b), 0);
      chk("done_b reset", 32'(done_b), 0);
      chk("wr_en_b reset", 32'(wen_b), 0);
      rst_a = 0; rst_b = 0;
      cnt_a = 0; err_am = 0; cnt_b = 0; err_bm = 0; sealed_b = 0;
   endtask

   task automatic step_a(input bit valid, input logic [2:0] c, input logic [2:0] fn3, input logic fb,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im, input bit use_k, input logic [31:0] k);
      bit ok, rdy;
      logic [31:0] w;
      va = valid; cls = c; f3 = fn3; f7 = fb; rd = d; rs1 = s1; rs2 = s2; imm = im;
      #1;
      rdy = cnt_a < 64;
      chk("req_ready_a", 32'(ready_a), 32'(rdy));
      if (valid && rdy) begin
         enc_ref(c, fn3, fb, d, s1, s2, im, ok, w);
         if (use_k) w = k;
         if (ok) begin qa.push_back({32'(cnt_a), w}); cnt_a++; end
         else err_am = 1;
      end
      @(negedge clk);
      va = 0;
      chk("count_a", 32'(count_a), 32'(cnt_a));
      chk("err_a", 32'(err_a), 32'(err_am));
      chk("done_a", 32'(done_a), 32'(cnt_a == 64));
   endtask

   task automatic step_b(input bit valid, input bit s, input logic [31:0] im);
      bit ok, rdy;
      logic [31:0] w;
      vb = valid; seal_b = s; cls = 3'd5; f3 = 3'd0; f7 = 0; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = im;
      #1;
      rdy = !sealed_b && cnt_b < 4;
      chk("req_ready_b", 32'(ready_b), 32'(rdy));
      if (valid && rdy) begin
         enc_ref(3'd5, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, im, ok, w);
         if (ok) begin qb.push_back({32'(cnt_b), w}); cnt_b++; end
         else err_bm = 1;
      end
      if (s && rdy) begin
         while (cnt_b < 4) begin qb.push_back({32'(cnt_b), 32'h00000013}); cnt_b++; end
         sealed_b = 1;
      end
      @(negedge clk);
      vb = 0; seal_b = 0;
      if (!sealed_b) chk("count_b", 32'(count_b), 32'(cnt_b));
      chk("err_b", 32'(err_b), 32'(err_bm));
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
         @(negedge clk);
         #1;
      end
      chk("queues drained", qa.size() + qb.size(), 0);
   endtask

   task automatic chk_full_b();
      chk("done_b", 32'(done_b), 1);
      chk("count_b full", 32'(count_b), 4);
      chk("req_ready_b full", 32'(ready_b), 0);
   endtask

   initial begin
      do_reset();
      step_a(1, 5, 0, 0, 1, 0, 0, 5, 1, 32'h00500093);
      step_a(1, 0, 0, 0, 2, 1, 0, 8, 1, 32'h0080A103);
      step_a(1, 2, 0, 0, 0, 1, 2, 4, 1, 32'h0020A223);
      step_a(1, 7, 0, 0, 5, 0, 0, 32'h12345000, 1, 32'h123452B7);
      step_a(1, 4, 0, 0, 0, 1, 2, -4, 1, 32'hFE208EE3);
      step_a(1, 6, 0, 0, 1, 0, 0, 8, 1, 32'h008000EF);
      step_a(1, 5, 5, 1, 3, 1, 0, 4, 1, 32'h4040D193);
      step_a(1, 5, 0, 0, 1, 1, 0, 4096, 0, 0);
      step_a(1, 4, 0, 0, 0, 1, 2, 3, 0, 0);
      step_a(1, 3, 0, 0, 3, 1, 2, 0, 1, 32'h002081B3);
      step_a(1, 5, 0, 0, 4, 2, 0, -2048, 0, 0);
      step_a(1, 5, 0, 0, 4, 2, 0, 2048, 0, 0);
      step_a(1, 5, 1, 0, 4, 2, 0, 31, 0, 0);
      step_a(1, 5, 1, 0, 4, 2, 0, 32, 0, 0);
      step_a(1, 4, 1, 0, 0, 3, 4, 4094, 0, 0);
      step_a(1, 4, 1, 0, 0, 3, 4, -4096, 0, 0);
      step_a(1, 4, 1, 0, 0, 3, 4, 4096, 0, 0);
      step_a(1, 6, 0, 0, 7, 0, 0, -1048576, 0, 0);
      step_a(1, 6, 0, 0, 7, 0, 0, 1048576, 0, 0);
      step_a(1, 7, 0, 0, 7, 0, 0, 32'h00000800, 0, 0);
      step_a(1, 2, 0, 0, 0, 5, 6, -2048, 0, 0);
      step_a(1, 2, 0, 0, 0, 5, 6, 2048, 0, 0);
      drain();
      for (int b = 0; b < 3; b++) begin
         do_reset();
         for (int i = 0; i < 90; i++)
            step_a($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), rand_imm(), 0, 0);
         drain();
      end
      do_reset();
      step_b(1, 0, 1);
      step_b(1, 0, 2);
      step_b(0, 1, 0);
      drain();
      chk_full_b();
      step_b(0, 1, 0);
      do_reset();
      for (int i = 0; i < 4; i++) step_b(1, 0, i);
      drain();
      chk_full_b();
      step_b(1, 0, 9);
      step_b(1, 0, 9);
      do_reset();
      step_b(1, 0, 7);
      step_b(1, 1, 9);
      drain();
      chk_full_b();
      do_reset();
      step_b(1, 0, 5);
      step_b(0, 1, 0);
      @(negedge clk);
      rst_b = 1;
      #1;
      chk("pad writes left at reset", qb.size(), 2);
      qb.delete();
      @(negedge clk);
      chk("wr_en_b after reset", 32'(wen_b), 0);
      chk("count_b after reset", 32'(count_b), 0);
      rst_b = 0; cnt_b = 0; sealed_b = 0; err_bm = 0;
      #1;
      chk("req_ready_b after reset", 32'(ready_b), 1);
      chk("done_b after reset", 32'(done_b), 0);
      step_b(1, 0, 3);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
